// File: rtl/mem_arbiter_if.sv
// Two-requester memory arbiter bus: requester ports, grant/done returns and RAM-controller side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16
);
  logic                 req0, req1;
  logic                 we0, we1;
  logic [ADDR_BITS-1:0] addr0, addr1;
  logic [DATA_BITS-1:0] wdata0, wdata1;
  logic                 gnt0, gnt1;
  logic                 done0, done1;
  logic [DATA_BITS-1:0] rdata0, rdata1;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_start_read, mem_start_write;
  logic [DATA_BITS-1:0] mem_rdata;
  logic                 mem_busy;
  logic                 busy;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_busy,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, mem_addr, mem_wdata,
           mem_start_read, mem_start_write, busy
  );

  // Requesters and RAM controller side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_busy,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, mem_addr, mem_wdata,
           mem_start_read, mem_start_write, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM controller between an instruction-fetch port (0)
// and a data port (1); one transaction at a time, no preemption.
module mem_arbiter #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               r_state;
  logic                 r_last;
  logic                 r_owner;
  logic                 r_we;
  logic                 r_gnt0, r_gnt1;
  logic                 r_done0, r_done1;
  logic                 r_start_rd, r_start_wr;
  logic                 r_busy;
  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [DATA_BITS-1:0] r_mem_wdata;
  logic [DATA_BITS-1:0] r_rdata0, r_rdata1;

  logic                 w_pick;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_wdata;

  // Lone requester wins; on a tie the port not served last wins
  assign w_pick  = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
  assign w_we    = w_pick ? bus.we1    : bus.we0;
  assign w_addr  = w_pick ? bus.addr1  : bus.addr0;
  assign w_wdata = w_pick ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_start_rd  <= 1'b0;
      r_start_wr  <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req0 || bus.req1) begin
            r_state     <= S_ISSUE;
            r_owner     <= w_pick;
            r_we        <= w_we;
            r_gnt0      <= ~w_pick;
            r_gnt1      <= w_pick;
            r_start_rd  <= ~w_we;
            r_start_wr  <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state    <= S_WAIT;
          r_start_rd <= 1'b0;
          r_start_wr <= 1'b0;
        end
        S_WAIT: begin
          // Controller reports completion by dropping mem_busy; read data is valid then
          if (!bus.mem_busy) begin
            r_state <= S_DONE;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            if (!r_we) begin
              if (r_owner) r_rdata1 <= bus.mem_rdata;
              else         r_rdata0 <= bus.mem_rdata;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_last      <= r_owner;
          r_done0     <= 1'b0;
          r_done1     <= 1'b0;
          r_gnt0      <= 1'b0;
          r_gnt1      <= 1'b0;
          r_busy      <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0            = r_gnt0;
  assign bus.gnt1            = r_gnt1;
  assign bus.done0           = r_done0;
  assign bus.done1           = r_done1;
  assign bus.rdata0          = r_rdata0;
  assign bus.rdata1          = r_rdata1;
  assign bus.mem_addr        = r_mem_addr;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.mem_start_read  = r_start_rd;
  assign bus.mem_start_write = r_start_wr;
  assign bus.busy            = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM-controller model with programmable stall, and a
// scoreboard of expected completions popped by a monitor on every done pulse.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(16)) bus ();

  mem_arbiter #(.ADDR_BITS(16), .DATA_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        port;
    logic [15:0] rd0;
    logic [15:0] rd1;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_pass = 0;
  int          n_total = 0;
  int          overlap = 0;
  int          stall = 0;
  int          cnt = 0;
  logic [15:0] ram [int unsigned];

  function automatic exp_t mk(input logic p, input logic [15:0] a, input logic [15:0] b);
    exp_t r;
    r.port = p;
    r.rd0  = a;
    r.rd1  = b;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   32'({bus.gnt1, bus.gnt0}), 0);
    check({tag, "_done"},  32'({bus.done1, bus.done0}), 0);
    check({tag, "_start"}, 32'({bus.mem_start_write, bus.mem_start_read}), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_maddr"}, 32'(bus.mem_addr), 0);
    check({tag, "_mwdat"}, 32'(bus.mem_wdata), 0);
  endtask

  // Single transaction held until its done pulse; returns cycles from request to done
  task automatic run_txn(input logic p, input logic w, input logic [15:0] a,
                         input logic [15:0] d, output int lat);
    lat = 0;
    if (p) begin bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; end
    do begin tick(); lat++; end while (!(p ? bus.done1 : bus.done0) && lat < 40);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // RAM controller model: busy for 'stall' cycles starting the cycle after a start strobe
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_busy <= 1'b0;
      cnt          <= 0;
    end else if (bus.mem_start_read || bus.mem_start_write) begin
      cnt          <= stall;
      bus.mem_busy <= (stall != 0);
      if (bus.mem_start_write) begin
        ram[32'(bus.mem_addr)] = bus.mem_wdata;
        bus.mem_rdata <= 16'hDEAD;
      end else begin
        bus.mem_rdata <= ram.exists(32'(bus.mem_addr)) ? ram[32'(bus.mem_addr)] : 16'h0000;
      end
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end else if (cnt == 1) begin
      cnt          <= 0;
      bus.mem_busy <= 1'b0;
    end
  end

  // Monitor: every done pulse must match the next queued completion
  always @(posedge clk) begin
    #2;
    if (bus.gnt0 && bus.gnt1) overlap++;
    if (rst_n && (bus.done0 || bus.done1)) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'({bus.done1, bus.done0}), 0);
      end else begin
        e = sb.pop_front();
        check("done_port", 32'({bus.done1, bus.done0}), e.port ? 32'd2 : 32'd1);
        check("rdata0", 32'(bus.rdata0), 32'(e.rd0));
        check("rdata1", 32'(bus.rdata1), 32'(e.rd1));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n, cyc, nwr, nrd, wbad, g1, first;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.mem_rdata = 16'h0000;
    ram[32'h0010] = 16'hBEEF;
    ram[32'h0020] = 16'h1111;
    ram[32'h0030] = 16'h2222;
    ram[32'h0040] = 16'h4444;
    tick(); tick();
    check_idle("rst");
    check("rst_rdata0", 32'(bus.rdata0), 0);
    check("rst_rdata1", 32'(bus.rdata1), 0);
    rst_n = 1'b1;
    tick();

    // Single read, no stall: strobe in cycle 2, done in cycle 4
    stall = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
    sb.push_back(mk(1'b0, 16'hBEEF, 16'h0000));
    tick();
    check("t1_start_rd", 32'(bus.mem_start_read), 1);
    check("t1_start_wr", 32'(bus.mem_start_write), 0);
    check("t1_maddr",    32'(bus.mem_addr), 32'h0010);
    check("t1_gnt",      32'({bus.gnt1, bus.gnt0}), 1);
    check("t1_busy",     32'(bus.busy), 1);
    tick();
    check("t1_start_off", 32'(bus.mem_start_read), 0);
    tick();
    check("t1_done0", 32'(bus.done0), 1);
    bus.req0 = 0;
    tick();
    check_idle("t1_idle");

    // Write with 5 busy cycles: done 5 cycles later than unstalled (8 vs 3)
    stall = 5;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h1234; bus.wdata1 = 16'hA5A5;
    sb.push_back(mk(1'b1, 16'hBEEF, 16'h0000));
    lat = 0; nwr = 0; nrd = 0; wbad = 0;
    do begin
      tick(); lat++;
      nwr += int'(bus.mem_start_write);
      nrd += int'(bus.mem_start_read);
      if (bus.gnt1 && bus.mem_wdata != 16'hA5A5) wbad++;
      if (bus.gnt1 && bus.mem_addr != 16'h1234) wbad++;
    end while (!bus.done1 && lat < 30);
    check("t2_latency", 32'(lat), 8);
    check("t2_wr_strobes", 32'(nwr), 1);
    check("t2_rd_strobes", 32'(nrd), 0);
    check("t2_wdata_hold", 32'(wbad), 0);
    bus.req1 = 0;
    tick();
    check_idle("t2_idle");

    // Reset so the tie test starts from the reset pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Both held high: service order 0,1,0,1, one done every 4 cycles
    stall = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0020;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0030;
    sb.push_back(mk(1'b0, 16'h1111, 16'h0000));
    sb.push_back(mk(1'b1, 16'h1111, 16'h2222));
    sb.push_back(mk(1'b0, 16'h1111, 16'h2222));
    sb.push_back(mk(1'b1, 16'h1111, 16'h2222));
    n = 0; cyc = 0;
    do begin
      tick(); cyc++;
      if (bus.done0 || bus.done1) n++;
      if (n == 4) begin bus.req0 = 0; bus.req1 = 0; end
    end while (n < 4 && cyc < 40);
    check("t3_services", 32'(n), 4);
    check("t3_cycles", 32'(cyc), 15);
    tick();
    check_idle("t3_idle");

    // Port 1 requests while port 0 waits: no grant or strobe for port 1 until after done0
    stall = 3;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0040;
    sb.push_back(mk(1'b0, 16'h4444, 16'h2222));
    tick(); tick();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0050; bus.wdata1 = 16'h5555;
    sb.push_back(mk(1'b1, 16'h4444, 16'h2222));
    cyc = 0; nwr = 0; g1 = 0;
    do begin
      tick(); cyc++;
      nwr += int'(bus.mem_start_read) + int'(bus.mem_start_write);
      g1  += int'(bus.gnt1);
    end while (!bus.done0 && cyc < 30);
    check("t4_done0", 32'(bus.done0), 1);
    check("t4_wait_strobes", 32'(nwr), 0);
    check("t4_wait_gnt1", 32'(g1), 0);
    bus.req0 = 0;
    cyc = 0; nwr = 0;
    do begin
      tick(); cyc++;
      nwr += int'(bus.mem_start_write);
    end while (!bus.done1 && cyc < 30);
    check("t4_done1", 32'(bus.done1), 1);
    check("t4_p1_strobes", 32'(nwr), 1);
    check("t4_p1_latency", 32'(cyc), 7);
    bus.req1 = 0;
    tick();
    check_idle("t4_idle");

    // Reset mid-WAIT abandons the transaction without a done pulse
    stall = 4;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
    tick(); tick(); tick();
    rst_n = 1'b0;
    bus.req0 = 0;
    tick();
    check_idle("t5_rst");
    check("t5_rdata0", 32'(bus.rdata0), 0);
    check("t5_rdata1", 32'(bus.rdata1), 0);
    rst_n = 1'b1;
    tick(); tick();
    check("t5_no_done", 32'({bus.done1, bus.done0}), 0);
    stall = 0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0010;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0030;
    sb.push_back(mk(1'b0, 16'hBEEF, 16'h0000));
    sb.push_back(mk(1'b1, 16'hBEEF, 16'h2222));
    n = 0; cyc = 0; first = -1;
    do begin
      tick(); cyc++;
      if (bus.done0) begin n++; bus.req0 = 0; if (first < 0) first = 0; end
      if (bus.done1) begin n++; bus.req1 = 0; if (first < 0) first = 1; end
    end while (n < 2 && cyc < 40);
    check("t5_first_winner", 32'(first), 0);
    check("t5_services", 32'(n), 2);
    tick();

    // req0 dropped during WAIT: transaction still completes with one done pulse
    stall = 3;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0020;
    sb.push_back(mk(1'b0, 16'h1111, 16'h2222));
    tick(); tick();
    bus.req0 = 0;
    cyc = 0;
    do begin tick(); cyc++; end while (!bus.done0 && cyc < 30);
    check("t6_done0", 32'(bus.done0), 1);
    check("t6_rdata0", 32'(bus.rdata0), 32'h1111);
    n = 0;
    for (int i = 0; i < 4; i++) begin tick(); n += int'(bus.done0); end
    check("t6_extra_done", 32'(n), 0);
    check_idle("t6_idle");

    // Read back the data written earlier through both ports
    stall = 1;
    sb.push_back(mk(1'b1, 16'h1111, 16'h5555));
    run_txn(1'b1, 1'b0, 16'h0050, 16'h0000, lat);
    check("t7_lat_p1", 32'(lat), 4);
    tick();
    sb.push_back(mk(1'b0, 16'hA5A5, 16'h5555));
    run_txn(1'b0, 1'b0, 16'h1234, 16'h0000, lat);
    check("t7_lat_p0", 32'(lat), 4);
    tick(); tick();

    check("sb_empty", 32'(sb.size()), 0);
    check("gnt_overlap", 32'(overlap), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
